// File: rtl/kf_host_ctrl_pkg.sv
// Shared kf definitions: word format constants for the kf_top core
// (sign-magnitude S9.14 data words, 5-bit data-bank address) and the
// host controller FSM state encoding.
package kf_host_ctrl_pkg;

  localparam int KF_W     = 24;  // data word width
  localparam int KF_FRAC  = 14;  // fractional bits of the S9.14 format
  localparam int KF_ADDRW = 5;   // data-bank address width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_RADDR,
    ST_RDATA,
    ST_OUT
  } kf_state_e;

endpackage

// File: rtl/kf_host_ctrl_fifo.sv
// kf_word_fifo: synchronous first-word-fall-through FIFO with a registered
// occupancy count. DEPTH must be a power of two (>= 2).
//   clk, rst    : clock, asynchronous active-high reset (empties the FIFO)
//   push        : write request; ignored while full
//   push_data   : word to write
//   pop         : read request; ignored while empty
//   head        : oldest word, valid whenever count != 0
//   count       : number of stored words (0..DEPTH)
//   full        : count == DEPTH
module kf_word_fifo
  import kf_host_ctrl_pkg::*;
#(
  parameter int W     = KF_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kf_host_ctrl.sv
// kf_host_ctrl: host-side sequencer for the kf_top Kalman filter core.
// Buffers host words in a FIFO, and on a run request streams NLOAD words
// into the core behind a one-cycle START pulse, waits for the core's
// READY handshake (with timeout), then reads NRD result words back from
// the data bank starting at RD_BASE and hands them out one at a time.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_data      : host word stream, accepted when in_ready
//   in_ready              : FIFO not full
//   run                   : request one filter run (ignored if < NLOAD queued)
//   busy                  : FSM not idle
//   kf_start, kf_data_in  : core START pulse and DATA_IN stream
//   kf_dir, kf_write      : core bank address and WRITE (always 0)
//   kf_ready, kf_data_out : core READY and DATA_OUT (1-cycle read latency)
//   out_valid/out_data/out_addr/out_ready : result word handshake
//   tmo_err               : sticky READY-timeout flag
module kf_host_ctrl
  import kf_host_ctrl_pkg::*;
#(
  parameter int W       = KF_W,
  parameter int ADDRW   = KF_ADDRW,
  parameter int NLOAD   = 6,
  parameter int RD_BASE = 0,
  parameter int NRD     = 2,
  parameter int FDEPTH  = 8,
  parameter int TMO     = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             run,
  output logic             busy,
  output logic             kf_start,
  output logic [W-1:0]     kf_data_in,
  output logic [ADDRW-1:0] kf_dir,
  output logic             kf_write,
  input  logic             kf_ready,
  input  logic [W-1:0]     kf_data_out,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [ADDRW-1:0] out_addr,
  input  logic             out_ready,
  output logic             tmo_err
);

  localparam int CW = $clog2(FDEPTH) + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam int IW = $clog2(NRD + 1);

  kf_state_e        state;
  kf_state_e        state_nxt;

  logic             fifo_push;
  logic             fifo_pop;
  logic [W-1:0]     fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;

  logic [CW-1:0]    feed_cnt;
  logic [TW-1:0]    wcnt;
  logic [TW-1:0]    wcnt_inc;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    rd_idx_inc;
  logic             rdy_seen_low;

  logic             run_accept;
  logic             tmo_hit;
  logic             to_raddr;
  logic [ADDRW-1:0] raddr_nxt;

  function automatic logic [ADDRW-1:0] rd_addr(input logic [IW-1:0] idx);
    return ADDRW'(RD_BASE) + ADDRW'(idx);
  endfunction

  kf_word_fifo #(
    .W     (W),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign busy       = (state != ST_IDLE);
  assign kf_write   = 1'b0;
  assign wcnt_inc   = (wcnt == TW'(TMO)) ? wcnt : wcnt + 1'b1;
  assign rd_idx_inc = rd_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    kf_start   = 1'b0;
    kf_data_in = '0;
    fifo_pop   = 1'b0;
    out_valid  = 1'b0;
    run_accept = 1'b0;
    tmo_hit    = 1'b0;
    to_raddr   = 1'b0;
    raddr_nxt  = rd_addr(rd_idx);
    case (state)
      ST_IDLE: begin
        if (run && (fifo_count >= CW'(NLOAD))) begin
          run_accept = 1'b1;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        kf_start   = 1'b1;
        kf_data_in = fifo_head;
        fifo_pop   = 1'b1;
        state_nxt  = (NLOAD > 1) ? ST_FEED : ST_WAIT;
      end
      ST_FEED: begin
        kf_data_in = fifo_head;
        fifo_pop   = 1'b1;
        if (feed_cnt == CW'(NLOAD - 1)) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A stale READY from the previous run must not end the wait; the
        // core has to drop READY first to show it has taken the job.
        if (rdy_seen_low && kf_ready) begin
          to_raddr  = 1'b1;
          state_nxt = ST_RADDR;
        end else if (wcnt_inc == TW'(TMO)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RADDR: state_nxt = ST_RDATA;
      ST_RDATA: state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_idx_inc < IW'(NRD)) begin
            to_raddr  = 1'b1;
            raddr_nxt = rd_addr(rd_idx_inc);
            state_nxt = ST_RADDR;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feed_cnt     <= '0;
      wcnt         <= '0;
      rd_idx       <= '0;
      rdy_seen_low <= 1'b0;
      tmo_err      <= 1'b0;
      kf_dir       <= '0;
      out_data     <= '0;
      out_addr     <= '0;
    end else begin
      if (run_accept) begin
        tmo_err      <= 1'b0;
        feed_cnt     <= '0;
        wcnt         <= '0;
        rd_idx       <= '0;
        rdy_seen_low <= 1'b0;
      end
      if (fifo_pop) begin
        feed_cnt <= feed_cnt + 1'b1;
      end
      // READY low is tracked from START on so a short drop while words are
      // still streaming in is not missed.
      if ((state inside {ST_START, ST_FEED, ST_WAIT}) && !kf_ready) begin
        rdy_seen_low <= 1'b1;
      end
      if (state == ST_WAIT) begin
        wcnt <= wcnt_inc;
      end
      if (tmo_hit) begin
        tmo_err <= 1'b1;
      end
      // kf_dir is loaded on entry to RADDR and otherwise holds.
      if (to_raddr) begin
        kf_dir <= raddr_nxt;
      end
      if (state == ST_RDATA) begin
        out_data <= kf_data_out;
        out_addr <= kf_dir;
      end
      if ((state == ST_OUT) && out_ready) begin
        rd_idx <= rd_idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_kf_host_ctrl.sv
module tb_kf_host_ctrl;

  localparam int W       = 24;
  localparam int ADDRW   = 5;
  localparam int NLOAD   = 6;
  localparam int RD_BASE = 0;
  localparam int NRD     = 2;
  localparam int FDEPTH  = 8;
  localparam int TMO     = 1023;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             run;
  logic             busy;
  logic             kf_start;
  logic [W-1:0]     kf_data_in;
  logic [ADDRW-1:0] kf_dir;
  logic             kf_write;
  logic             kf_ready;
  logic [W-1:0]     kf_data_out;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [ADDRW-1:0] out_addr;
  logic             out_ready;
  logic             tmo_err;

  kf_host_ctrl #(
    .W       (W),
    .ADDRW   (ADDRW),
    .NLOAD   (NLOAD),
    .RD_BASE (RD_BASE),
    .NRD     (NRD),
    .FDEPTH  (FDEPTH),
    .TMO     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .run         (run),
    .busy        (busy),
    .kf_start    (kf_start),
    .kf_data_in  (kf_data_in),
    .kf_dir      (kf_dir),
    .kf_write    (kf_write),
    .kf_ready    (kf_ready),
    .kf_data_out (kf_data_out),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_ready   (out_ready),
    .tmo_err     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the core data bank: synchronous read, one cycle latency.
  logic [W-1:0] bank [1 << ADDRW];
  always @(posedge clk) kf_data_out <= bank[kf_dir];

  int           n_checks;
  int           n_pass;
  logic [W-1:0] mq[$];   // reference model of the FIFO contents

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic push_word(input logic [W-1:0] w);
    check("in_ready", 32'(in_ready), 32'(mq.size() < FDEPTH));
    in_valid = 1'b1;
    in_data  = w;
    if (mq.size() < FDEPTH) mq.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ":kf_start"},   32'(kf_start),   0);
    check({nm, ":kf_data_in"}, 32'(kf_data_in), 0);
    check({nm, ":kf_dir"},     32'(kf_dir),     0);
    check({nm, ":kf_write"},   32'(kf_write),   0);
    check({nm, ":out_valid"},  32'(out_valid),  0);
    check({nm, ":out_data"},   32'(out_data),   0);
    check({nm, ":out_addr"},   32'(out_addr),   0);
    check({nm, ":busy"},       32'(busy),       0);
    check({nm, ":tmo_err"},    32'(tmo_err),    0);
    check({nm, ":in_ready"},   32'(in_ready),   1);
  endtask

  // One complete run. low_len == 0 means READY never drops (timeout case).
  // Cycle c counts negedges after run is raised; c == 1 is the START cycle.
  task automatic run_once(input int low_at, input int low_len, input int stall,
                          input bit cpush, input string nm);
    logic [W-1:0]     exp_w [NLOAD];
    logic [W-1:0]     w;
    logic [ADDRW-1:0] ea;
    int c, rise, first_ov, nacc, stall_left;
    bit done, expect_tmo, cp;
    for (int i = 0; i < NLOAD; i++) exp_w[i] = mq.pop_front();
    cp         = cpush && (mq.size() == 0);
    expect_tmo = (low_len == 0);
    rise       = low_at + low_len;
    run = 1'b1; kf_ready = 1'b1; out_ready = 1'b0;
    c = 0; done = 1'b0; first_ov = -1; nacc = 0; stall_left = stall;
    while (!done && c < TMO + 200) begin
      @(negedge clk);
      c++;
      run = 1'b0;
      if (c == 1) begin
        check({nm, ":start"}, 32'(kf_start), 1);
        check({nm, ":tmo_clr"}, 32'(tmo_err), 0);
      end else if (c <= NLOAD + 1) begin
        check({nm, ":start_low"}, 32'(kf_start), 0);
      end
      if (c <= NLOAD) begin
        check({nm, ":data_in"}, 32'(kf_data_in), 32'(exp_w[c-1]));
      end else if (c == NLOAD + 1) begin
        check({nm, ":data_in_zero"}, 32'(kf_data_in), 0);
        check({nm, ":busy_wait"}, 32'(busy), 1);
      end
      if (cp) begin
        if (c <= NLOAD) begin
          w = W'($urandom);
          check({nm, ":cpush_ready"}, 32'(in_ready), 1);
          in_valid = 1'b1; in_data = w; mq.push_back(w);
        end else begin
          in_valid = 1'b0;
        end
      end
      kf_ready = !(!expect_tmo && c >= low_at && c < rise);
      if (expect_tmo) begin
        if (c == NLOAD + TMO) begin
          check({nm, ":tmo_pre"}, 32'(tmo_err), 0);
          check({nm, ":busy_pre"}, 32'(busy), 1);
        end
        if (c == NLOAD + 1 + TMO) begin
          check({nm, ":tmo_set"}, 32'(tmo_err), 1);
          check({nm, ":tmo_idle"}, 32'(busy), 0);
          check({nm, ":tmo_no_out"}, 32'(first_ov == -1), 1);
          done = 1'b1;
        end
      end else if (c == rise + 1) begin
        check({nm, ":dir0"}, 32'(kf_dir), 32'(RD_BASE % (1 << ADDRW)));
      end
      if (out_ready) begin
        nacc++;
        out_ready  = 1'b0;
        stall_left = stall;
        check({nm, ":ov_drop"}, 32'(out_valid), 0);
        if (nacc == NRD) begin
          check({nm, ":idle_end"}, 32'(busy), 0);
          done = 1'b1;
        end
      end else if (out_valid) begin
        if (first_ov < 0) begin
          first_ov = c;
          check({nm, ":first_out_cyc"}, 32'(c), expect_tmo ? 0 : 32'(rise + 3));
        end
        ea = ADDRW'((RD_BASE + nacc) % (1 << ADDRW));
        check({nm, ":out_addr"}, 32'(out_addr), 32'(ea));
        check({nm, ":out_data"}, 32'(out_data), 32'(bank[ea]));
        if (stall_left == 0) out_ready = 1'b1;
        else stall_left--;
      end
    end
    in_valid = 1'b0;
    if (!done) check({nm, ":cycle_bound"}, 0, 1);
  endtask

  initial begin
    logic [W-1:0] req21 [6];
    n_checks = 0; n_pass = 0;
    req21[0] = 24'h004000; req21[1] = 24'h0000A3; req21[2] = 24'h000666;
    req21[3] = 24'h000000; req21[4] = 24'h004000; req21[5] = 24'h00A000;
    for (int i = 0; i < (1 << ADDRW); i++) bank[i] = W'($urandom);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; run = 1'b0;
    kf_ready = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst:in_ready", 32'(in_ready), 1);
    check("post_rst:busy", 32'(busy), 0);

    // Directed load sequence, delayed READY handshake, stalled consumer.
    for (int i = 0; i < 6; i++) push_word(req21[i]);
    run_once(12, 40, 5, 1'b0, "req21");

    // Run with only NLOAD-1 words queued is ignored.
    for (int i = 0; i < NLOAD - 1; i++) push_word(W'($urandom));
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b0;
      check("short:kf_start", 32'(kf_start), 0);
      check("short:busy", 32'(busy), 0);
    end
    push_word(W'($urandom));
    run_once(10, 3, 0, 1'b0, "req22");

    // READY never drops: timeout, then the next run clears the flag.
    for (int i = 0; i < NLOAD; i++) push_word(W'($urandom));
    run_once(0, 0, 0, 1'b0, "tmo");
    repeat (3) @(negedge clk);
    check("tmo:sticky", 32'(tmo_err), 1);

    // Overflow: only FDEPTH words accepted, the rest dropped.
    for (int i = 0; i < FDEPTH + 2; i++) push_word(W'($urandom));
    check("ovf:in_ready_full", 32'(in_ready), 0);
    run_once(NLOAD + 2, 7, 1, 1'b0, "ovf1");
    while (mq.size() < NLOAD) push_word(W'($urandom));
    run_once(NLOAD + 1, 1, 2, 1'b0, "ovf2");

    // Randomized runs, some with pushes overlapping the feed.
    for (int it = 0; it < 10; it++) begin
      while (mq.size() < NLOAD) push_word(W'($urandom));
      if ($urandom_range(0, 1) == 1 && mq.size() < FDEPTH) push_word(W'($urandom));
      run_once(NLOAD + 1 + int'($urandom_range(0, 20)), 1 + int'($urandom_range(0, 40)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
    end

    // Reset in the middle of FEED.
    while (mq.size() < FDEPTH) push_word(W'($urandom));
    kf_ready = 1'b1;
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst:busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NLOAD; i++) push_word(W'($urandom));
    run_once(NLOAD + 3, 5, 0, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
